// File: rtl/ev2_pcie_packer.sv
// ev2 event packer: pairs 16-bit event words into 32-bit entries and drains them to the DMA FIFO.
// Optional macro EV2_PACKER_STATS_EN adds words_o, a count of 32-bit words popped to DMA.
module ev2_pcie_packer #(
  parameter int DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] ev2_dat_i,
  input  logic        ev2_wr_i,
  output logic        ev2_full_o,
  output logic [15:0] ev2_count_o,
  input  logic        ev2_rst_i,
  output logic        ev2_rst_ack_o,
  output logic [31:0] dma_dat_o,
  output logic        dma_wr_o,
  input  logic        dma_full_i,
  output logic        overflow_o
`ifdef EV2_PACKER_STATS_EN
  ,
  output logic [31:0] words_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] FULL_TH_C = DEPTH_C - {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] ONE_C = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           half_q, half_d;
  logic [15:0]    low_q, low_d;
  logic           ovf_q, ovf_d;
  logic           full_q, full_d;
  logic           ack_q, ack_d;
  logic [15:0]    count_q, count_d;
  logic [31:0]    mem_q [DEPTH];

  logic [PTR_W:0] used_s;
  logic [PTR_W:0] used_next_s;
  logic           empty_s;
  logic           pop_s;
  logic           push_s;
  logic           flush_s;

`ifdef EV2_PACKER_STATS_EN
  logic [31:0] words_q, words_d;
`endif

  assign used_s  = wr_ptr_q - rd_ptr_q;
  assign empty_s = (used_s == {(PTR_W + 1){1'b0}});
  assign pop_s   = !empty_s && !dma_full_i && (state_q == ST_RUN);
  // Flush clears on the entry edge as well as while held in FLUSH, so writes are ignored throughout.
  assign flush_s = ev2_rst_i || (state_q == ST_FLUSH);

  // Next-state logic for the flush FSM, packer, pointers and status registers.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    half_d   = half_q;
    low_d    = low_q;
    ovf_d    = ovf_q;
    push_s   = 1'b0;
`ifdef EV2_PACKER_STATS_EN
    words_d  = words_q;
`endif

    case (state_q)
      ST_RUN:   state_d = ev2_rst_i ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_d = ev2_rst_i ? ST_FLUSH : ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    if (flush_s) begin
      wr_ptr_d = {(PTR_W + 1){1'b0}};
      rd_ptr_d = {(PTR_W + 1){1'b0}};
      half_d   = 1'b0;
      ovf_d    = 1'b0;
`ifdef EV2_PACKER_STATS_EN
      words_d  = 32'd0;
`endif
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + ONE_C;
`ifdef EV2_PACKER_STATS_EN
        words_d  = words_q + 32'd1;
`endif
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (ev2_wr_i) begin
        if (!half_q) begin
          low_d  = ev2_dat_i;
          half_d = 1'b1;
        end else if (used_s == DEPTH_C) begin
          // Dropping the whole pair keeps the next write on the low half.
          ovf_d  = 1'b1;
          half_d = 1'b0;
        end else begin
          push_s   = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE_C;
          half_d   = 1'b0;
        end
      end else begin
        half_d = half_q;
      end
    end

    used_next_s = wr_ptr_d - rd_ptr_d;
    full_d      = (used_next_s >= FULL_TH_C) || (state_d == ST_FLUSH);
    ack_d       = (state_d == ST_FLUSH);
    count_d     = 16'({used_next_s, 1'b0}) + {15'd0, half_d};
  end

  // State and status registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= {(PTR_W + 1){1'b0}};
      rd_ptr_q <= {(PTR_W + 1){1'b0}};
      half_q   <= 1'b0;
      low_q    <= 16'd0;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
      ack_q    <= 1'b0;
      count_q  <= 16'd0;
`ifdef EV2_PACKER_STATS_EN
      words_q  <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      half_q   <= half_d;
      low_q    <= low_d;
      ovf_q    <= ovf_d;
      full_q   <= full_d;
      ack_q    <= ack_d;
      count_q  <= count_d;
`ifdef EV2_PACKER_STATS_EN
      words_q  <= words_d;
`endif
    end
  end

  // Buffer storage; contents are qualified by the pointers, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= {ev2_dat_i, low_q};
    end
  end

  assign dma_wr_o      = pop_s;
  assign dma_dat_o     = empty_s ? 32'd0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign ev2_full_o    = full_q;
  assign ev2_count_o   = count_q;
  assign ev2_rst_ack_o = ack_q;
  assign overflow_o    = ovf_q;
`ifdef EV2_PACKER_STATS_EN
  assign words_o       = words_q;
`endif

endmodule

// File: tb/tb_ev2_pcie_packer.sv
// Scoreboard bench for ev2_pcie_packer: a queue of expected 32-bit entries, checked as the DUT drains.
module tb_ev2_pcie_packer;
  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [15:0] ev2_dat_i;
  logic        ev2_wr_i;
  logic        ev2_full_o;
  logic [15:0] ev2_count_o;
  logic        ev2_rst_i;
  logic        ev2_rst_ack_o;
  logic [31:0] dma_dat_o;
  logic        dma_wr_o;
  logic        dma_full_i;
  logic        overflow_o;
`ifdef EV2_PACKER_STATS_EN
  logic [31:0] words_o;
`endif

  ev2_pcie_packer #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .ev2_dat_i    (ev2_dat_i),
    .ev2_wr_i     (ev2_wr_i),
    .ev2_full_o   (ev2_full_o),
    .ev2_count_o  (ev2_count_o),
    .ev2_rst_i    (ev2_rst_i),
    .ev2_rst_ack_o(ev2_rst_ack_o),
    .dma_dat_o    (dma_dat_o),
    .dma_wr_o     (dma_wr_o),
    .dma_full_i   (dma_full_i),
    .overflow_o   (overflow_o)
`ifdef EV2_PACKER_STATS_EN
    ,
    .words_o      (words_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int unsigned vectors_s = 0;
  int unsigned miscompares_s = 0;

  logic [31:0] sb_q [$];
  logic        m_half;
  logic [15:0] m_low;
  logic        m_ovf;
  logic        m_flush;
  int unsigned m_words;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors_s++;
    if (got !== exp) begin
      miscompares_s++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb_q.delete();
    m_half  = 1'b0;
    m_low   = 16'd0;
    m_ovf   = 1'b0;
    m_flush = 1'b0;
    m_words = 0;
  endtask

  // One clock: drive at negedge, check the combinational drain, advance the model, check registered state.
  task automatic tick(input logic wr, input logic [15:0] dat);
    logic exp_wr;
    int   pre;
    ev2_wr_i  = wr;
    ev2_dat_i = dat;
    #1;
    exp_wr = (sb_q.size() != 0) && !dma_full_i && !m_flush;
    check("dma_wr", {31'd0, dma_wr_o}, {31'd0, exp_wr});
    if (exp_wr && dma_wr_o) check("dma_dat", dma_dat_o, sb_q[0]);
    if (ev2_rst_i || m_flush) begin
      sb_q.delete();
      m_half  = 1'b0;
      m_ovf   = 1'b0;
      m_words = 0;
    end else begin
      pre = sb_q.size();
      if (exp_wr) begin
        void'(sb_q.pop_front());
        m_words++;
      end
      if (wr) begin
        if (!m_half) begin
          m_low  = dat;
          m_half = 1'b1;
        end else if (pre == DEPTH) begin
          m_ovf  = 1'b1;
          m_half = 1'b0;
        end else begin
          sb_q.push_back({dat, m_low});
          m_half = 1'b0;
        end
      end
    end
    m_flush = ev2_rst_i;
    @(posedge clk_i);
    @(negedge clk_i);
    check("count", {16'd0, ev2_count_o}, 32'(2 * sb_q.size() + int'(m_half)));
    check("full", {31'd0, ev2_full_o}, {31'd0, (sb_q.size() >= DEPTH - 1) || m_flush});
    check("rst_ack", {31'd0, ev2_rst_ack_o}, {31'd0, m_flush});
    check("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
`ifdef EV2_PACKER_STATS_EN
    check("words", words_o, m_words);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'd0);
  endtask

  initial begin
    rst_n_i    = 1'b0;
    ev2_dat_i  = 16'd0;
    ev2_wr_i   = 1'b0;
    ev2_rst_i  = 1'b0;
    dma_full_i = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_i);
    check("rst_full", {31'd0, ev2_full_o}, 32'd0);
    check("rst_count", {16'd0, ev2_count_o}, 32'd0);
    check("rst_ack", {31'd0, ev2_rst_ack_o}, 32'd0);
    check("rst_dma_wr", {31'd0, dma_wr_o}, 32'd0);
    check("rst_dma_dat", dma_dat_o, 32'd0);
    check("rst_ovf", {31'd0, overflow_o}, 32'd0);
    rst_n_i = 1'b1;

    // Basic packing of two pairs.
    tick(1'b1, 16'h1111);
    tick(1'b1, 16'h2222);
    check("first_pair_head", dma_dat_o, 32'h2222_1111);
    tick(1'b1, 16'h3333);
    tick(1'b1, 16'h4444);
    check("second_pair_head", dma_dat_o, 32'h4444_3333);
    idle(3);
    check("count_zero", {16'd0, ev2_count_o}, 32'd0);

    // Fill with DMA blocked, upstream stops on full.
    dma_full_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (ev2_full_o) break;
      tick(1'b1, 16'(16'h5000 + i));
    end
    check("full_reached", {31'd0, ev2_full_o}, 32'd1);
    check("count_on_full", {16'd0, ev2_count_o}, 32'd30);
    check("ovf_on_full", {31'd0, overflow_o}, 32'd0);

    // Force writes past full: one pair fits, the following pairs are dropped.
    for (int i = 0; i < 6; i++) tick(1'b1, 16'(16'hF000 + i));
    check("ovf_set", {31'd0, overflow_o}, 32'd1);
    check("count_at_depth", {16'd0, ev2_count_o}, 32'd32);
    dma_full_i = 1'b0;
    idle(20);
    check("drained", {16'd0, ev2_count_o}, 32'd0);

    // Odd write then flush; next pair must start on the low half.
    tick(1'b1, 16'hA001);
    tick(1'b1, 16'hA002);
    tick(1'b1, 16'hA003);
    ev2_rst_i = 1'b1;
    tick(1'b0, 16'd0);
    check("ack_rise", {31'd0, ev2_rst_ack_o}, 32'd1);
    for (int i = 0; i < 4; i++) tick(1'b1, 16'(16'hDEAD + i));
    check("flush_count", {16'd0, ev2_count_o}, 32'd0);
    check("flush_ovf", {31'd0, overflow_o}, 32'd0);
    ev2_rst_i = 1'b0;
    tick(1'b1, 16'hBEEF);
    check("ack_fall", {31'd0, ev2_rst_ack_o}, 32'd0);
    tick(1'b1, 16'hAAAA);
    tick(1'b1, 16'hBBBB);
    check("post_flush_pair", dma_dat_o, 32'hBBBB_AAAA);
    idle(3);

    // Steady push and pop at used=8.
    dma_full_i = 1'b1;
    for (int i = 0; i < 16; i++) tick(1'b1, 16'(16'h6000 + i));
    check("used8_start", {16'd0, ev2_count_o}, 32'd16);
    for (int i = 0; i < 20; i++) begin
      dma_full_i = m_half ? 1'b0 : 1'b1;
      tick(1'b1, 16'(16'h7000 + i));
      check("used8_hold", {17'd0, ev2_count_o[15:1]}, 32'd8);
    end
    dma_full_i = 1'b0;
    idle(20);

`ifdef EV2_PACKER_STATS_EN
    ev2_rst_i = 1'b1;
    tick(1'b0, 16'd0);
    ev2_rst_i = 1'b0;
    tick(1'b0, 16'd0);
    for (int i = 0; i < 20; i++) tick(1'b1, 16'(16'h8000 + i));
    idle(3);
    check("words_ten", words_o, 32'd10);
    ev2_rst_i = 1'b1;
    tick(1'b0, 16'd0);
    check("words_flush", words_o, 32'd0);
    ev2_rst_i = 1'b0;
    tick(1'b0, 16'd0);
`endif

    // Asynchronous reset mid-operation, between clock edges.
    dma_full_i = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b1, 16'(16'h9000 + i));
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_count", {16'd0, ev2_count_o}, 32'd0);
    check("arst_dat", dma_dat_o, 32'd0);
    check("arst_full", {31'd0, ev2_full_o}, 32'd0);
    model_clear();
    @(negedge clk_i);
    rst_n_i    = 1'b1;
    dma_full_i = 1'b0;
    tick(1'b1, 16'hC0DE);
    tick(1'b1, 16'hCAFE);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_s, miscompares_s);
    $finish;
  end

endmodule
